// File: rtl/video_text_render_pkg.sv
// Shared types and field positions for the text-mode display memory and render pipeline.
package video_text_render_pkg;

  typedef logic [15:0] disp_addr_t;
  typedef logic [15:0] disp_data_t;
  typedef logic [3:0]  color_t;

  localparam int DISP_CHAR_LSB  = 0;
  localparam int DISP_FORE_LSB  = 8;
  localparam int DISP_BACK_LSB  = 12;
  localparam int RENDER_LATENCY = 3;

endpackage

// File: rtl/video_text_render_sync_delay.sv
// N-stage shift register that keeps timing strobes aligned with a fixed-latency pixel pipeline.
module video_sync_delay #(
  parameter int STAGES = 3,
  parameter int WIDTH  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[STAGES-1];

endmodule

// File: rtl/video_text_render.sv
// Text-mode renderer: raster-scans character/attribute memory, fetches glyph rows from the
// font ROM and emits one 4-bit color index per pixel, three cycles behind the timing inputs.
module video_text_render
  import video_text_render_pkg::*;
#(
  parameter int TEXT_COLS = 80,
  parameter int TEXT_ROWS = 30,
  parameter int FONT_H    = 16,
  parameter int FONT_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        visible_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        eof_i,
  input  disp_addr_t  disp_base_i,
  output logic        rd_en_o,
  output disp_addr_t  rd_addr_o,
  input  disp_data_t  rd_data_i,
  output logic [11:0] font_addr_o,
  input  logic [7:0]  font_data_i,
  output color_t      color_o,
  output logic        visible_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam int              CW        = $clog2(TEXT_COLS + 1);
  localparam logic [CW-1:0]   COLS_C    = CW'(TEXT_COLS);
  localparam logic [3:0]      SCAN_LAST = 4'(FONT_H - 1);

  if (FONT_W != 8 || FONT_H < 1 || FONT_H > 16 || (FONT_H & (FONT_H - 1)) != 0 ||
      TEXT_ROWS < 1) begin : g_param_check
    $error("video_text_render: unsupported text geometry");
  end

  logic          armed_q;
  logic [2:0]    x_q, x_d;
  logic [CW-1:0] col_q, col_d;
  logic [3:0]    scan_q, scan_d;
  disp_addr_t    line_base_q, line_base_d;

  logic          active_p0, first_p0, inr_p0, line_end;
  logic          vld_p1_q, first_p1_q, inr_p1_q, rd_p1_q;
  logic [3:0]    scan_p1_q;
  logic          vld_p2_q, first_p2_q, inr_p2_q;
  color_t        fore_p2_q, back_p2_q;
  logic [7:0]    shift_q, shift_d;
  color_t        fore_q, fore_d, back_q, back_d;
  color_t        color_q, color_d;
  logic [2:0]    sync_q;

  // Stage 0: addressing. armed_q holds off rendering after reset until visible has been low.
  assign active_p0 = visible_i & armed_q;
  assign first_p0  = (x_q == 3'd0);
  assign inr_p0    = (col_q < COLS_C);
  assign rd_en_o   = active_p0 & first_p0 & inr_p0;
  assign rd_addr_o = rd_en_o ? line_base_q + disp_addr_t'(col_q) : '0;
  assign line_end  = vld_p1_q & ~visible_i;

  always_comb begin
    x_d         = x_q;
    col_d       = col_q;
    scan_d      = scan_q;
    line_base_d = line_base_q;
    if (eof_i) begin
      x_d         = '0;
      col_d       = '0;
      scan_d      = '0;
      line_base_d = disp_base_i;
    end else if (line_end) begin
      x_d   = '0;
      col_d = '0;
      if (scan_q == SCAN_LAST) begin
        scan_d      = '0;
        line_base_d = line_base_q + disp_addr_t'(TEXT_COLS);
      end else begin
        scan_d = scan_q + 4'd1;
      end
    end else if (active_p0) begin
      x_d = x_q + 3'd1;
      if (x_q == 3'd7 && inr_p0) col_d = col_q + CW'(1);
    end
  end

  // Stage 1: glyph row lookup from the returned character code.
  assign font_addr_o = rd_p1_q ? {rd_data_i[DISP_CHAR_LSB +: 8], scan_p1_q} : '0;

  // Stage 2: shifter loads on a cell's first pixel, otherwise walks toward the MSB.
  always_comb begin
    shift_d = first_p2_q ? font_data_i : {shift_q[6:0], 1'b0};
    fore_d  = first_p2_q ? fore_p2_q : fore_q;
    back_d  = first_p2_q ? back_p2_q : back_q;
    color_d = '0;
    if (vld_p2_q && inr_p2_q) color_d = shift_d[7] ? fore_d : back_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q     <= 1'b0;
      x_q         <= '0;
      col_q       <= '0;
      scan_q      <= '0;
      line_base_q <= '0;
      vld_p1_q    <= 1'b0;
      first_p1_q  <= 1'b0;
      inr_p1_q    <= 1'b0;
      rd_p1_q     <= 1'b0;
      vld_p2_q    <= 1'b0;
      first_p2_q  <= 1'b0;
      inr_p2_q    <= 1'b0;
      color_q     <= '0;
    end else begin
      armed_q     <= armed_q | ~visible_i;
      x_q         <= x_d;
      col_q       <= col_d;
      scan_q      <= scan_d;
      line_base_q <= line_base_d;
      vld_p1_q    <= active_p0;
      first_p1_q  <= first_p0;
      inr_p1_q    <= inr_p0;
      rd_p1_q     <= rd_en_o;
      vld_p2_q    <= vld_p1_q;
      first_p2_q  <= first_p1_q;
      inr_p2_q    <= inr_p1_q;
      color_q     <= color_d;
    end
  end

  always_ff @(posedge clk) begin
    scan_p1_q <= scan_q;
    if (rd_p1_q) begin
      fore_p2_q <= rd_data_i[DISP_FORE_LSB +: 4];
      back_p2_q <= rd_data_i[DISP_BACK_LSB +: 4];
    end
    shift_q <= shift_d;
    fore_q  <= fore_d;
    back_q  <= back_d;
  end

  assign color_o = color_q;

  video_sync_delay #(
    .STAGES (RENDER_LATENCY),
    .WIDTH  (3)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     ({visible_i, hsync_i, vsync_i}),
    .q_o     (sync_q)
  );

  assign {visible_o, hsync_o, vsync_o} = sync_q;

endmodule

// File: tb/tb_video_text_render.sv
// Directed bench for video_text_render with behavioural display memory and font ROM.
module tb_video_text_render;
  import video_text_render_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        visible_i, hsync_i, vsync_i, eof_i;
  disp_addr_t  disp_base_i;
  logic        rd_en_o;
  disp_addr_t  rd_addr_o;
  disp_data_t  rd_data_i;
  logic [11:0] font_addr_o;
  logic [7:0]  font_data_i;
  color_t      color_o;
  logic        visible_o, hsync_o, vsync_o;

  always #5 clk = ~clk;

  video_text_render dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .visible_i   (visible_i),
    .hsync_i     (hsync_i),
    .vsync_i     (vsync_i),
    .eof_i       (eof_i),
    .disp_base_i (disp_base_i),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .font_addr_o (font_addr_o),
    .font_data_i (font_data_i),
    .color_o     (color_o),
    .visible_o   (visible_o),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o)
  );

  disp_data_t mem [0:65535];
  logic [7:0] rom [0:4095];

  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
    font_data_i <= rom[font_addr_o];
  end

  int checks = 0;
  int fails  = 0;
  int ncyc;
  logic prev_rd;
  disp_addr_t  addr_q[$];
  int          acyc_q[$];
  logic [3:0]  font_q[$];
  color_t      col_h[$];
  logic        vis_h[$];
  logic        hs_h[$];
  logic        vs_h[$];

  task automatic clear_hist();
    addr_q.delete(); acyc_q.delete(); font_q.delete();
    col_h.delete(); vis_h.delete(); hs_h.delete(); vs_h.delete();
    ncyc = 0;
    prev_rd = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic hs, input logic vs, input logic e);
    @(negedge clk);
    visible_i = v; hsync_i = hs; vsync_i = vs; eof_i = e;
    #1;
    if (prev_rd) font_q.push_back(font_addr_o[3:0]);
    prev_rd = rd_en_o;
    if (rd_en_o) begin
      addr_q.push_back(rd_addr_o);
      acyc_q.push_back(ncyc);
    end
    col_h.push_back(color_o);
    vis_h.push_back(visible_o);
    hs_h.push_back(hsync_o);
    vs_h.push_back(vsync_o);
    ncyc++;
  endtask

  task automatic run_line(input int npix, input int nblank, input logic eof_fall);
    for (int i = 0; i < npix; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nblank; i++) cyc(1'b0, (i >= 2 && i < 6), 1'b0, (i == 0) && eof_fall);
  endtask

  task automatic do_eof(input disp_addr_t base);
    disp_base_i = base;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      visible_i = i[0]; hsync_i = i[1]; vsync_i = i[2]; eof_i = 1'b0;
      #1;
      outs = {7'd0, rd_en_o, rd_addr_o, font_addr_o, color_o, visible_o, hsync_o, vsync_o};
      checks++;
      if (outs !== 48'd0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: outputs=%0h expected 0", i, outs);
      end
    end
    @(negedge clk);
    visible_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_first_line();
    clear_hist();
    run_line(640, 10, 1'b0);
    checks++;
    if (addr_q.size() !== 80) begin
      fails++;
      $display("FAIL first_line_reads: got %0d reads, expected 80", addr_q.size());
    end else begin
      for (int i = 0; i < 80; i++) begin
        checks++;
        if (addr_q[i] !== disp_addr_t'(i) || acyc_q[i] !== 8 * i) begin
          fails++;
          $display("FAIL first_line_addr %0d: got addr %0h at cycle %0d, expected addr %0h at cycle %0d",
                   i, addr_q[i], acyc_q[i], i, 8 * i);
        end
      end
    end
  endtask

  task automatic test_row_stepping();
    for (int l = 1; l <= 32; l++) begin
      clear_hist();
      run_line(16, 4, 1'b0);
      checks++;
      if (addr_q.size() !== 2 || font_q.size() !== 2) begin
        fails++;
        $display("FAIL row_step_reads line %0d: got %0d reads, expected 2", l, addr_q.size());
      end else begin
        checks++;
        if (addr_q[0] !== disp_addr_t'(80 * (l / 16))) begin
          fails++;
          $display("FAIL row_step_addr line %0d: got %0h, expected %0h", l, addr_q[0], 80 * (l / 16));
        end
        checks++;
        if (font_q[0] !== 4'(l % 16)) begin
          fails++;
          $display("FAIL row_step_scanline line %0d: got %0d, expected %0d", l, font_q[0], l % 16);
        end
      end
    end
  endtask

  task automatic test_single_cell();
    color_t exp_cell [8];
    exp_cell = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    do_eof(16'h0000);
    clear_hist();
    run_line(16, 6, 1'b0);
    checks++;
    if (vis_h[2] !== 1'b0 || vis_h[3] !== 1'b1) begin
      fails++;
      $display("FAIL single_visible_latency: got t+2=%0b t+3=%0b, expected 0 1", vis_h[2], vis_h[3]);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (col_h[3 + k] !== exp_cell[k]) begin
        fails++;
        $display("FAIL single_cell_pixel %0d: got %0d, expected %0d", k, col_h[3 + k], exp_cell[k]);
      end
    end
    checks++;
    if (col_h[11] !== 4'd0 || col_h[2] !== 4'd0) begin
      fails++;
      $display("FAIL single_cell_border: got %0d/%0d, expected 0/0", col_h[2], col_h[11]);
    end
  endtask

  task automatic test_base_wrap();
    do_eof(16'hFFF0);
    clear_hist();
    run_line(640, 10, 1'b0);
    checks++;
    if (addr_q.size() !== 80) begin
      fails++;
      $display("FAIL wrap_reads: got %0d reads, expected 80", addr_q.size());
    end else begin
      for (int i = 0; i < 80; i++) begin
        checks++;
        if (addr_q[i] !== disp_addr_t'(16'hFFF0 + i) || acyc_q[i] !== 8 * i) begin
          fails++;
          $display("FAIL wrap_addr %0d: got %0h at cycle %0d, expected %0h at cycle %0d",
                   i, addr_q[i], acyc_q[i], disp_addr_t'(16'hFFF0 + i), 8 * i);
        end
      end
    end
  endtask

  task automatic test_overlong();
    do_eof(16'h0000);
    clear_hist();
    run_line(660, 10, 1'b0);
    checks++;
    if (addr_q.size() !== 80 || addr_q[addr_q.size() - 1] !== 16'd79) begin
      fails++;
      $display("FAIL overlong_reads: got %0d reads last %0h, expected 80 last 4f",
               addr_q.size(), addr_q[addr_q.size() - 1]);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (col_h[3 + 632 + k] !== 4'd5) begin
        fails++;
        $display("FAIL overlong_last_cell px %0d: got %0d, expected 5", 632 + k, col_h[3 + 632 + k]);
      end
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (col_h[3 + 640 + k] !== 4'd0 || vis_h[3 + 640 + k] !== 1'b1) begin
        fails++;
        $display("FAIL overlong_extra px %0d: got color %0d vis %0b, expected 0 1",
                 640 + k, col_h[3 + 640 + k], vis_h[3 + 640 + k]);
      end
    end
  endtask

  task automatic test_eof_fall();
    do_eof(16'h0000);
    run_line(16, 4, 1'b0);
    disp_base_i = 16'h0200;
    run_line(16, 4, 1'b1);
    clear_hist();
    run_line(16, 4, 1'b0);
    checks++;
    if (addr_q.size() === 0 || addr_q[0] !== 16'h0200) begin
      fails++;
      $display("FAIL eof_fall_addr: got %0h (%0d reads), expected 200", addr_q[0], addr_q.size());
    end
    checks++;
    if (font_q.size() === 0 || font_q[0] !== 4'd0) begin
      fails++;
      $display("FAIL eof_fall_scanline: got %0d, expected 0", font_q[0]);
    end
  endtask

  task automatic test_sync_delay();
    logic [7:0] hsp, vsp;
    hsp = 8'b1011_0010;
    vsp = 8'b0110_1001;
    clear_hist();
    for (int k = 0; k < 8; k++) cyc(1'b0, hsp[k], vsp[k], 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hs_h[k + 3] !== hsp[k] || vs_h[k + 3] !== vsp[k]) begin
        fails++;
        $display("FAIL sync_delay %0d: got hs=%0b vs=%0b, expected hs=%0b vs=%0b",
                 k, hs_h[k + 3], vs_h[k + 3], hsp[k], vsp[k]);
      end
    end
  endtask

  task automatic test_reset_midline();
    do_eof(16'h0000);
    clear_hist();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (col_h[5] !== 4'd2 || vis_h[5] !== 1'b1) begin
      fails++;
      $display("FAIL midline_pre: got color %0d vis %0b, expected 2 1", col_h[5], vis_h[5]);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (color_o !== 4'd0 || visible_o !== 1'b0 || rd_en_o !== 1'b0) begin
      fails++;
      $display("FAIL midline_reset_async: got color %0d vis %0b rd %0b, expected 0 0 0",
               color_o, visible_o, rd_en_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_hist();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (addr_q.size() !== 0 || col_h[9] !== 4'd0) begin
      fails++;
      $display("FAIL midline_hold: got %0d reads color %0d, expected 0 reads color 0",
               addr_q.size(), col_h[9]);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clear_hist();
    run_line(16, 6, 1'b0);
    checks++;
    if (addr_q.size() === 0 || addr_q[0] !== 16'h0000 || font_q[0] !== 4'd0) begin
      fails++;
      $display("FAIL midline_restart: got addr %0h scan %0d, expected 0 0", addr_q[0], font_q[0]);
    end
    checks++;
    if (col_h[3] !== 4'd2 || col_h[4] !== 4'd1) begin
      fails++;
      $display("FAIL midline_restart_px: got %0d %0d, expected 2 1", col_h[3], col_h[4]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    visible_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; eof_i = 1'b0;
    disp_base_i = '0;
    rd_data_i = '0;
    font_data_i = '0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    mem[0]  = 16'h1241;
    mem[79] = 16'h5300;
    rom[12'h410] = 8'b1010_0000;
    clear_hist();

    test_reset();
    test_first_line();
    test_row_stepping();
    test_single_cell();
    test_base_wrap();
    test_overlong();
    test_eof_fall();
    test_sync_delay();
    test_reset_midline();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
